// File: rtl/mxint8_blk_seq.sv
`timescale 1ns/1ps
// mxint8_blk_seq
// Collects one MX block of FP32 elements, derives the block's shared E8M0 scale
// from the largest element exponent, then replays the elements in arrival order
// to the FP32->INT8 quantizer along with that scale.
module mxint8_blk_seq #(
  parameter  int BLK_SIZE = 32,
  localparam int IDX_W    = $clog2(BLK_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [31:0]      q_data,
  output logic [7:0]       q_shared_exp,
  output logic [IDX_W-1:0] q_idx,
  output logic             q_last,
  output logic             blk_nan,
  output logic             busy
);

  // state | meaning
  // FILL  | accepting elements into the buffer, tracking max exponent and NaN/Inf
  // SCALE | single cycle: publish shared scale, prime first replay element
  // DRAIN | replaying buffered elements to the quantizer in arrival order

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SCALE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BLK_SIZE - 1);

  state_e           state_q;
  logic [IDX_W-1:0] wr_cnt_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] rd_idx_d;
  logic [7:0]       max_exp_q;
  logic             nan_seen_q;
  logic             q_valid_q;
  logic             q_last_q;
  logic             blk_nan_q;
  logic [31:0]      q_data_q;
  logic [7:0]       q_shared_exp_q;
  logic [31:0]      mem_q [BLK_SIZE];
  logic [7:0]       in_exp;
  logic             in_fire;
  logic             q_fire;

  // in_ready is gated by rst so nothing is accepted on the reset edge.
  assign in_exp   = in_data[30:23];
  assign in_ready = (state_q == FILL) && !rst;
  assign in_fire  = in_valid && in_ready;
  assign q_fire   = q_valid_q && q_ready;
  assign rd_idx_d = rd_idx_q + IDX_W'(1);

  assign q_valid      = q_valid_q;
  assign q_data       = q_data_q;
  assign q_shared_exp = q_shared_exp_q;
  assign q_idx        = rd_idx_q;
  assign q_last       = q_last_q;
  assign blk_nan      = blk_nan_q;
  assign busy         = (state_q != FILL) || (wr_cnt_q != '0);

  // Element buffer; contents are meaningless until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[wr_cnt_q] <= in_data;
    end
  end

  // Block sequencing FSM with registered quantizer-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FILL;
      wr_cnt_q       <= '0;
      rd_idx_q       <= '0;
      max_exp_q      <= '0;
      nan_seen_q     <= 1'b0;
      q_valid_q      <= 1'b0;
      q_data_q       <= '0;
      q_shared_exp_q <= '0;
      q_last_q       <= 1'b0;
      blk_nan_q      <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_fire) begin
            wr_cnt_q <= wr_cnt_q + IDX_W'(1);
            if (in_exp > max_exp_q) begin
              max_exp_q <= in_exp;
            end
            if (in_exp == 8'hFF) begin
              nan_seen_q <= 1'b1;
            end
            if (wr_cnt_q == LAST_IDX) begin
              state_q <= SCALE;
            end
          end
        end
        SCALE: begin
          // Any NaN/Inf element poisons the whole block's scale.
          q_shared_exp_q <= nan_seen_q ? 8'hFF : max_exp_q;
          blk_nan_q      <= nan_seen_q;
          rd_idx_q       <= FIRST_IDX;
          q_data_q       <= mem_q[FIRST_IDX];
          q_last_q       <= 1'b0;
          q_valid_q      <= 1'b1;
          state_q        <= DRAIN;
        end
        DRAIN: begin
          if (q_fire) begin
            rd_idx_q <= rd_idx_d;
            if (q_last_q) begin
              q_valid_q  <= 1'b0;
              q_last_q   <= 1'b0;
              max_exp_q  <= '0;
              nan_seen_q <= 1'b0;
              state_q    <= FILL;
            end else begin
              q_data_q <= mem_q[rd_idx_d];
              q_last_q <= (rd_idx_d == LAST_IDX);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mxint8_blk_seq.sv
`timescale 1ns/1ps
module tb_mxint8_blk_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        q_valid;
  logic        q_ready;
  logic [31:0] q_data;
  logic [7:0]  q_shared_exp;
  logic [4:0]  q_idx;
  logic        q_last;
  logic        blk_nan;
  logic        busy;

  mxint8_blk_seq #(.BLK_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
    .q_shared_exp(q_shared_exp), .q_idx(q_idx), .q_last(q_last),
    .blk_nan(blk_nan), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] blk      [32];
  logic [31:0] got_data [32];
  logic [4:0]  got_idx  [32];
  logic        got_last [32];
  logic [7:0]  got_exp  [32];
  logic        got_nan  [32];
  int n_got, accept_cyc, first_qv_cyc, end_cyc;
  bit tmo, stall_bad, inr_bad;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer blk[0..n-1] upstream; gap_pct is the chance of in_valid being low per cycle.
  task automatic fill_block(input int n, input int gap_pct);
    int i = 0;
    int budget = 0;
    bit hs;
    tmo = 0;
    while (i < n && budget < 2000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = blk[i];
      hs = in_valid && in_ready;
      step();
      budget++;
      if (hs) i++;
    end
    if (i < n) tmo = 1;
    in_valid   = 1'b0;
    accept_cyc = cyc;
  endtask

  // Collect 32 quantizer handshakes; upstream pushes junk the whole time to show it is refused.
  task automatic drain_block(input int rdy_pct);
    int budget = 0;
    bit stalled = 0;
    logic [31:0] pd;
    logic [4:0]  pi;
    logic [7:0]  pe;
    logic        pn;
    n_got = 0; stall_bad = 0; inr_bad = 0; first_qv_cyc = -1;
    while (n_got < 32 && budget < 3000) begin
      q_ready  = ($urandom_range(99) < rdy_pct);
      in_valid = 1'b1;
      in_data  = 32'h4F12_3456;
      if (in_ready !== 1'b0) inr_bad = 1;
      if (q_valid === 1'b1) begin
        if (first_qv_cyc < 0) first_qv_cyc = cyc;
        if (stalled && (q_data !== pd || q_idx !== pi || q_shared_exp !== pe || blk_nan !== pn))
          stall_bad = 1;
        if (q_ready) begin
          got_data[n_got] = q_data;
          got_idx[n_got]  = q_idx;
          got_last[n_got] = q_last;
          got_exp[n_got]  = q_shared_exp;
          got_nan[n_got]  = blk_nan;
          n_got++;
          stalled = 0;
        end else begin
          stalled = 1;
          pd = q_data; pi = q_idx; pe = q_shared_exp; pn = blk_nan;
        end
      end
      step();
      budget++;
    end
    if (n_got < 32) tmo = 1;
    in_valid = 1'b0;
    q_ready  = 1'b0;
    end_cyc  = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; q_ready = 1'b0; in_data = '0;
    step(); step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready);
    end
    checks++;
    if ({q_valid, q_last, blk_nan, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got v=%0b l=%0b n=%0b b=%0b expected all 0",
                          q_valid, q_last, blk_nan, busy);
    end
    checks++;
    if (q_data !== 32'h0 || q_shared_exp !== 8'h0 || q_idx !== 5'd0) begin
      errors++; $display("FAIL reset_data: got data=%h exp=%h idx=%0d expected 0/0/0",
                          q_data, q_shared_exp, q_idx);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset: got in_ready=%0b busy=%0b expected 1/0", in_ready, busy);
    end
  endtask

  task automatic test_uniform();
    for (int i = 0; i < 32; i++) blk[i] = 32'h3F80_0000;
    fill_block(32, 0);
    drain_block(100);
    checks++;
    if (tmo || n_got != 32) begin
      errors++; $display("FAIL uni_count: got %0d handshakes (timeout=%0b) expected 32", n_got, tmo);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_idx[i] !== 5'(i) || got_last[i] !== (i == 31) || got_exp[i] !== 8'h7F ||
          got_data[i] !== 32'h3F80_0000) begin
        errors++; $display("FAIL uni_elem%0d: got idx=%0d last=%0b exp=%h data=%h expected %0d/%0b/7f/3f800000",
                            i, got_idx[i], got_last[i], got_exp[i], got_data[i], i, (i == 31));
      end
    end
    checks++;
    if (first_qv_cyc - accept_cyc + 1 != 2) begin
      errors++; $display("FAIL uni_latency: got q_valid in cycle %0d after accept expected 2",
                          first_qv_cyc - accept_cyc + 1);
    end
    checks++;
    if (inr_bad || in_ready !== 1'b1 || end_cyc - accept_cyc + 1 != 34) begin
      errors++; $display("FAIL uni_in_ready: got low_violation=%0b in_ready=%0b rise_cycle=%0d expected 0/1/34",
                          inr_bad, in_ready, end_cyc - accept_cyc + 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL uni_junk_ignored: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_mixed();
    for (int i = 0; i < 32; i++)
      blk[i] = (i % 2 == 0) ? (32'h3F80_0000 | 32'(i << 10)) : (32'hBE00_0000 | 32'(i));
    blk[13] = 32'hC300_0000;
    blk[20] = 32'h42FE_0000;
    fill_block(32, 0);
    drain_block(100);
    checks++;
    if (tmo || n_got != 32) begin
      errors++; $display("FAIL mix_count: got %0d expected 32", n_got);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_data[i] !== blk[i] || got_exp[i] !== 8'h86 || got_nan[i] !== 1'b0 || got_idx[i] !== 5'(i)) begin
        errors++; $display("FAIL mix_elem%0d: got data=%h exp=%h nan=%0b expected %h/86/0",
                            i, got_data[i], got_exp[i], got_nan[i], blk[i]);
      end
    end
  endtask

  task automatic test_nan();
    for (int i = 0; i < 32; i++) blk[i] = 32'h4000_0000 + 32'(i);
    blk[7] = 32'h7FC0_0000;
    fill_block(32, 0);
    drain_block(100);
    checks++;
    if (tmo || n_got != 32) begin
      errors++; $display("FAIL nan_count: got %0d expected 32", n_got);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_data[i] !== blk[i] || got_exp[i] !== 8'hFF || got_nan[i] !== 1'b1) begin
        errors++; $display("FAIL nan_elem%0d: got data=%h exp=%h nan=%0b expected %h/ff/1",
                            i, got_data[i], got_exp[i], got_nan[i], blk[i]);
      end
    end
  endtask

  task automatic test_zero_sub();
    for (int i = 0; i < 32; i++)
      case (i % 4)
        0:       blk[i] = 32'h0000_0000;
        1:       blk[i] = 32'h0000_0001;
        2:       blk[i] = 32'h8000_0000;
        default: blk[i] = 32'h807F_FFFF;
      endcase
    fill_block(32, 0);
    drain_block(100);
    checks++;
    if (tmo || n_got != 32) begin
      errors++; $display("FAIL zero_count: got %0d expected 32", n_got);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_data[i] !== blk[i] || got_exp[i] !== 8'h00 || got_nan[i] !== 1'b0) begin
        errors++; $display("FAIL zero_elem%0d: got data=%h exp=%h expected %h/00",
                            i, got_data[i], got_exp[i], blk[i]);
      end
    end
    // Rounding-edge vectors: carry, tie, max finite; largest exponent is 0xFE.
    for (int i = 0; i < 32; i++)
      case (i % 5)
        0:       blk[i] = 32'h3F7F_FFFF;
        1:       blk[i] = 32'h3FC0_0000;
        2:       blk[i] = 32'h3F40_0000;
        3:       blk[i] = 32'h7F7F_FFFF;
        default: blk[i] = 32'hBF80_0001;
      endcase
    fill_block(32, 0);
    drain_block(100);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_data[i] !== blk[i] || got_exp[i] !== 8'hFE || got_nan[i] !== 1'b0) begin
        errors++; $display("FAIL edge_elem%0d: got data=%h exp=%h expected %h/fe",
                            i, got_data[i], got_exp[i], blk[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int total = 0;
    logic [7:0] mx, e, exp_scale;
    bit nan, bad;
    for (int b = 0; b < 100; b++) begin
      mx = 8'h00; nan = 0;
      for (int i = 0; i < 32; i++) begin
        blk[i] = $urandom;
        if ($urandom_range(199) == 0) blk[i][30:23] = 8'hFF;
        e = blk[i][30:23];
        if (e > mx) mx = e;
        if (e == 8'hFF) nan = 1;
      end
      exp_scale = nan ? 8'hFF : mx;
      fill_block(32, 30);
      drain_block(50);
      total += n_got;
      bad = 0;
      for (int i = 0; i < 32; i++)
        if (got_data[i] !== blk[i] || got_idx[i] !== 5'(i) || got_exp[i] !== exp_scale ||
            got_nan[i] !== nan || got_last[i] !== (i == 31)) bad = 1;
      checks++;
      if (tmo || bad) begin
        errors++; $display("FAIL b2b_block%0d: got timeout=%0b elem_mismatch=%0b expected 0/0 (scale %h)",
                            b, tmo, bad, exp_scale);
      end
      checks++;
      if (stall_bad || inr_bad) begin
        errors++; $display("FAIL b2b_stall%0d: got unstable=%0b in_ready_high=%0b expected 0/0",
                            b, stall_bad, inr_bad);
      end
    end
    checks++;
    if (total != 3200) begin
      errors++; $display("FAIL b2b_total: got %0d handshakes expected 3200", total);
    end
  endtask

  task automatic test_mid_reset();
    int budget = 0;
    for (int i = 0; i < 32; i++) blk[i] = 32'h4800_0000 | 32'(i);
    fill_block(17, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL partial_busy: got %0b expected 1", busy);
    end
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || q_valid !== 1'b0 || q_shared_exp !== 8'h00) begin
      errors++; $display("FAIL fill_rst: got busy=%0b in_ready=%0b q_valid=%0b exp=%h expected 0/0/0/00",
                          busy, in_ready, q_valid, q_shared_exp);
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < 32; i++) blk[i] = 32'h4000_0000 | 32'(i << 4);
    blk[5] = 32'h3F00_0000;
    fill_block(32, 0);
    drain_block(100);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_data[i] !== blk[i] || got_exp[i] !== 8'h80 || got_nan[i] !== 1'b0 || got_idx[i] !== 5'(i)) begin
        errors++; $display("FAIL after_fill_rst%0d: got data=%h exp=%h idx=%0d expected %h/80/%0d",
                            i, got_data[i], got_exp[i], got_idx[i], blk[i], i);
      end
    end
    // Mid-drain reset on a NaN block.
    for (int i = 0; i < 32; i++) blk[i] = 32'h4500_0000 | 32'(i);
    blk[3] = 32'hFF80_0000;
    fill_block(32, 0);
    q_ready = 1'b1;
    while (!(q_valid === 1'b1 && q_idx === 5'd9) && budget < 100) begin
      step();
      budget++;
    end
    q_ready = 1'b0;
    checks++;
    if (q_valid !== 1'b1 || q_idx !== 5'd9 || blk_nan !== 1'b1 || q_data !== blk[9]) begin
      errors++; $display("FAIL pre_drain_rst: got v=%0b idx=%0d nan=%0b data=%h expected 1/9/1/%h",
                          q_valid, q_idx, blk_nan, q_data, blk[9]);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({q_valid, q_last, blk_nan, busy, in_ready} !== 5'b0 || q_data !== 32'h0 ||
        q_shared_exp !== 8'h0 || q_idx !== 5'd0) begin
      errors++; $display("FAIL drain_rst: got v=%0b l=%0b n=%0b b=%0b r=%0b data=%h exp=%h idx=%0d expected zeros",
                          q_valid, q_last, blk_nan, busy, in_ready, q_data, q_shared_exp, q_idx);
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < 32; i++) blk[i] = 32'h4080_0000 | 32'(i * 3);
    fill_block(32, 0);
    drain_block(100);
    checks++;
    if (tmo || n_got != 32) begin
      errors++; $display("FAIL after_drain_rst_count: got %0d expected 32", n_got);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_data[i] !== blk[i] || got_exp[i] !== 8'h81 || got_nan[i] !== 1'b0 || got_idx[i] !== 5'(i)) begin
        errors++; $display("FAIL after_drain_rst%0d: got data=%h exp=%h nan=%0b expected %h/81/0",
                            i, got_data[i], got_exp[i], got_nan[i], blk[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_mixed();
    test_nan();
    test_zero_sub();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
